// File: rtl/bullet_slot_arbiter_if.sv
// Bus between the game-state FSM / emitters and the bullet slot arbiter.
interface bullet_slot_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned NSLOT  = 16,
  parameter int unsigned SLOT_W = 4
) ();
  logic              game_en;
  logic              game_reset;
  logic              bomb_clear;
  logic [NREQ-1:0]   req;
  logic              release_valid;
  logic [SLOT_W-1:0] release_slot;
  logic [NREQ-1:0]   gnt;
  logic              gnt_valid;
  logic [SLOT_W-1:0] gnt_slot;
  logic              flush_valid;
  logic [SLOT_W-1:0] flush_slot;
  logic [NSLOT-1:0]  slot_busy;
  logic [SLOT_W:0]   busy_count;
  logic              full;
  logic [7:0]        drop_count;

  modport master (
    output game_en, game_reset, bomb_clear, req, release_valid, release_slot,
    input  gnt, gnt_valid, gnt_slot, flush_valid, flush_slot, slot_busy, busy_count, full,
           drop_count
  );

  modport slave (
    input  game_en, game_reset, bomb_clear, req, release_valid, release_slot,
    output gnt, gnt_valid, gnt_slot, flush_valid, flush_slot, slot_busy, busy_count, full,
           drop_count
  );
endinterface

// File: rtl/bullet_slot_arbiter.sv
// Round-robin spawn arbiter over a pool of bullet slots, with slot flush sequencing.
module bullet_slot_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned NSLOT  = 16,
  parameter int unsigned SLOT_W = 4
) (
  input logic                 clk,
  input logic                 hard_reset_n,
  bullet_slot_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StOff, StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [SLOT_W-1:0] gnt_slot_q, gnt_slot_d;
  logic              flush_valid_q, flush_valid_d;
  logic [SLOT_W-1:0] flush_slot_q, flush_slot_d;
  logic [NSLOT-1:0]  slot_busy_q, slot_busy_d;
  logic [SLOT_W:0]   busy_count_q, busy_count_d;
  logic              full_q, full_d;
  logic [7:0]        drop_count_q, drop_count_d;

  logic              win_any, win_hi;
  logic [PtrW-1:0]   win_idx_any, win_idx_hi, win_idx;
  logic              free_found;
  logic [SLOT_W-1:0] free_idx;

  // Round-robin winner: lowest requester at or above rr_ptr, else lowest overall (wrap).
  always_comb begin
    win_any     = 1'b0;
    win_hi      = 1'b0;
    win_idx_any = '0;
    win_idx_hi  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!win_any && bus.req[k]) begin
        win_any     = 1'b1;
        win_idx_any = PtrW'(k);
      end
      if (!win_hi && bus.req[k] && (k >= 32'(rr_ptr_q))) begin
        win_hi     = 1'b1;
        win_idx_hi = PtrW'(k);
      end
    end
    win_idx = win_hi ? win_idx_hi : win_idx_any;
  end

  // Lowest free slot, taken from the registered bitmap (ignores this cycle's release).
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      if (!free_found && !slot_busy_q[k]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(k);
      end
    end
  end

  // Next-state: flush entry has priority, then release, then arbitration.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = '0;
    gnt_valid_d   = 1'b0;
    gnt_slot_d    = gnt_slot_q;
    flush_valid_d = 1'b0;
    flush_slot_d  = flush_slot_q;
    slot_busy_d   = slot_busy_q;
    drop_count_d  = drop_count_q;

    if (bus.game_reset) begin
      state_d        = StFlush;
      flush_valid_d  = 1'b1;
      flush_slot_d   = '0;
      slot_busy_d[0] = 1'b0;
      rr_ptr_d       = '0;
      drop_count_d   = '0;
    end else begin
      unique case (state_q)
        StFlush: begin
          // flush_slot_q doubles as the sweep counter.
          if (flush_slot_q == SLOT_W'(NSLOT - 1)) begin
            state_d = bus.game_en ? StRun : StOff;
          end else begin
            flush_valid_d             = 1'b1;
            flush_slot_d              = flush_slot_q + SLOT_W'(1);
            slot_busy_d[flush_slot_d] = 1'b0;
          end
        end
        StOff, StRun: begin
          if (bus.bomb_clear) begin
            state_d        = StFlush;
            flush_valid_d  = 1'b1;
            flush_slot_d   = '0;
            slot_busy_d[0] = 1'b0;
          end else begin
            if (bus.release_valid) slot_busy_d[bus.release_slot] = 1'b0;
            if (state_q == StOff) begin
              if (bus.game_en) state_d = StRun;
            end else if (!bus.game_en) begin
              state_d = StOff;
            end else if (win_any) begin
              if (free_found) begin
                gnt_d[win_idx]        = 1'b1;
                gnt_valid_d           = 1'b1;
                gnt_slot_d            = free_idx;
                slot_busy_d[free_idx] = 1'b1;
                rr_ptr_d = (win_idx == PtrW'(NREQ - 1)) ? '0 : win_idx + PtrW'(1);
              end else if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
              end
            end
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  // Occupancy summaries follow the next bitmap so they register alongside it.
  always_comb begin
    busy_count_d = '0;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      busy_count_d = busy_count_d + (SLOT_W + 1)'(slot_busy_d[k]);
    end
    full_d = &slot_busy_d;
  end

  // FSM and all registered outputs.
  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state_q       <= StOff;
      rr_ptr_q      <= '0;
      gnt_q         <= '0;
      gnt_valid_q   <= 1'b0;
      gnt_slot_q    <= '0;
      flush_valid_q <= 1'b0;
      flush_slot_q  <= '0;
      slot_busy_q   <= '0;
      busy_count_q  <= '0;
      full_q        <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_q         <= gnt_d;
      gnt_valid_q   <= gnt_valid_d;
      gnt_slot_q    <= gnt_slot_d;
      flush_valid_q <= flush_valid_d;
      flush_slot_q  <= flush_slot_d;
      slot_busy_q   <= slot_busy_d;
      busy_count_q  <= busy_count_d;
      full_q        <= full_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_valid   = gnt_valid_q;
  assign bus.gnt_slot    = gnt_slot_q;
  assign bus.flush_valid = flush_valid_q;
  assign bus.flush_slot  = flush_slot_q;
  assign bus.slot_busy   = slot_busy_q;
  assign bus.busy_count  = busy_count_q;
  assign bus.full        = full_q;
  assign bus.drop_count  = drop_count_q;

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Directed bench for bullet_slot_arbiter with a grant scoreboard.
module tb_bullet_slot_arbiter;

  logic clk = 1'b0;
  logic hard_reset_n = 1'b0;

  always #5 clk = ~clk;

  bullet_slot_arbiter_if #(.NREQ(4), .NSLOT(16), .SLOT_W(4)) bus ();

  bullet_slot_arbiter #(.NREQ(4), .NSLOT(16), .SLOT_W(4)) dut (
    .clk          (clk),
    .hard_reset_n (hard_reset_n),
    .bus          (bus)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] slot;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge and retire one scoreboard entry.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("gnt", 32'(bus.gnt), 32'(e.gnt));
      chk("gnt_valid", 32'(bus.gnt_valid), 32'(|e.gnt));
      if (e.gnt != 4'b0) chk("gnt_slot", 32'(bus.gnt_slot), 32'(e.slot));
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] eg, input logic [3:0] es);
    bus.req = r;
    sb.push_back('{eg, es});
    tick();
  endtask

  task automatic rel(input logic [3:0] s);
    bus.req           = 4'b0;
    bus.release_valid = 1'b1;
    bus.release_slot  = s;
    sb.push_back('{4'b0, 4'b0});
    tick();
    bus.release_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_gnt_valid"}, 32'(bus.gnt_valid), 0);
    chk({tag, "_gnt_slot"}, 32'(bus.gnt_slot), 0);
    chk({tag, "_flush_valid"}, 32'(bus.flush_valid), 0);
    chk({tag, "_flush_slot"}, 32'(bus.flush_slot), 0);
    chk({tag, "_slot_busy"}, 32'(bus.slot_busy), 0);
    chk({tag, "_busy_count"}, 32'(bus.busy_count), 0);
    chk({tag, "_full"}, 32'(bus.full), 0);
    chk({tag, "_drop"}, 32'(bus.drop_count), 0);
  endtask

  // Pulse a flush source, then expect a 16-cycle sweep with no grants while r is held.
  task automatic full_flush(input bit use_reset, input logic [3:0] r);
    if (use_reset) bus.game_reset = 1'b1;
    else bus.bomb_clear = 1'b1;
    bus.req = r;
    for (int k = 0; k < 16; k++) begin
      sb.push_back('{4'b0, 4'b0});
      tick();
      bus.game_reset = 1'b0;
      bus.bomb_clear = 1'b0;
      chk("flush_valid", 32'(bus.flush_valid), 1);
      chk("flush_slot", 32'(bus.flush_slot), 32'(k));
      chk("flush_cleared", 32'(bus.slot_busy[k]), 0);
    end
    bus.req = 4'b0;
    sb.push_back('{4'b0, 4'b0});
    tick();
    chk("flush_end", 32'(bus.flush_valid), 0);
    chk("flush_busy", 32'(bus.slot_busy), 0);
    chk("flush_count", 32'(bus.busy_count), 0);
  endtask

  initial begin
    bus.game_en       = 1'b0;
    bus.game_reset    = 1'b0;
    bus.bomb_clear    = 1'b0;
    bus.req           = 4'b0;
    bus.release_valid = 1'b0;
    bus.release_slot  = 4'd0;

    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    hard_reset_n = 1'b1;

    // 1: single request after entering RUN.
    bus.game_en = 1'b1;
    tick();
    drive(4'b0001, 4'b0001, 4'd0);
    chk("t1_busy", 32'(bus.slot_busy), 32'h0001);
    chk("t1_count", 32'(bus.busy_count), 1);
    drive(4'b0000, 4'b0000, 4'd0);

    // Return to a clean pool with rr_ptr=0.
    full_flush(1'b1, 4'b1111);
    chk("gr_drop", 32'(bus.drop_count), 0);

    // 2: all requesters rotate.
    drive(4'b1111, 4'b0001, 4'd0);
    drive(4'b1111, 4'b0010, 4'd1);
    drive(4'b1111, 4'b0100, 4'd2);
    drive(4'b1111, 4'b1000, 4'd3);
    drive(4'b1111, 4'b0001, 4'd4);
    chk("t2_count", 32'(bus.busy_count), 5);

    // 3: fill the pool, then drops when full.
    for (int s = 5; s < 16; s++) drive(4'b0001, 4'b0001, 4'(s));
    chk("t3_full", 32'(bus.full), 1);
    chk("t3_count", 32'(bus.busy_count), 16);
    for (int k = 0; k < 3; k++) drive(4'b0001, 4'b0000, 4'd0);
    chk("t3_drop", 32'(bus.drop_count), 3);
    chk("t3_still_full", 32'(bus.full), 1);
    rel(4'd5);
    chk("t3_rel_full", 32'(bus.full), 0);
    chk("t3_rel_busy", 32'(bus.slot_busy), 32'hFFDF);
    drive(4'b0001, 4'b0001, 4'd5);
    chk("t3_refull", 32'(bus.full), 1);

    // 4: release of a free slot is a no-op; grant+release keeps the count.
    rel(4'd2);
    chk("t4_rel2", 32'(bus.busy_count), 15);
    rel(4'd2);
    chk("t4_rel2_again_busy", 32'(bus.slot_busy), 32'hFFFB);
    chk("t4_rel2_again_cnt", 32'(bus.busy_count), 15);
    for (int s = 3; s < 10; s++) rel(4'(s));
    chk("t4_count8", 32'(bus.busy_count), 8);
    bus.release_valid = 1'b1;
    bus.release_slot  = 4'd12;
    drive(4'b0001, 4'b0001, 4'd2);
    bus.release_valid = 1'b0;
    chk("t4_same_cycle_cnt", 32'(bus.busy_count), 8);
    chk("t4_same_cycle_busy", 32'(bus.slot_busy), 32'hEC07);

    // 5: bomb clear with 10 busy slots.
    drive(4'b0001, 4'b0001, 4'd3);
    drive(4'b0001, 4'b0001, 4'd4);
    chk("t5_count10", 32'(bus.busy_count), 10);
    full_flush(1'b0, 4'b1111);
    chk("t5_drop", 32'(bus.drop_count), 3);
    drive(4'b0010, 4'b0010, 4'd0);
    drive(4'b0000, 4'b0000, 4'd0);

    // 6: game_reset mid-sweep restarts it; hard reset aborts it.
    bus.bomb_clear = 1'b1;
    sb.push_back('{4'b0, 4'b0});
    tick();
    bus.bomb_clear = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    chk("t6_at7", 32'(bus.flush_slot), 7);
    chk("t6_drop_kept", 32'(bus.drop_count), 3);
    bus.game_reset = 1'b1;
    tick();
    bus.game_reset = 1'b0;
    chk("t6_restart_slot", 32'(bus.flush_slot), 0);
    chk("t6_restart_valid", 32'(bus.flush_valid), 1);
    chk("t6_restart_drop", 32'(bus.drop_count), 0);
    tick();
    tick();
    chk("t6_slot2", 32'(bus.flush_slot), 2);
    #2;
    hard_reset_n = 1'b0;
    #1;
    chk_reset_vals("midflush");
    @(negedge clk);
    hard_reset_n = 1'b1;
    tick();
    chk("post_reset_idle", 32'(bus.flush_valid), 0);
    chk("post_reset_gnt", 32'(bus.gnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_slot_arbiter.md
Name: bullet_slot_arbiter

Overview:
- Shares the fixed pool of bullet slots in the bullet RAM among several emitters: player gun, boss emitters and enemy waves.
- Round-robin arbitration grants at most one spawn per cycle and allocates the lowest-index free slot.
- Tracks slot occupancy and frees slots on release.
- Sequences a slot-by-slot flush of the bullet RAM on game reset or bomb activation; sits between the game-state FSM and the bullet datapath.

Parameters:
- NREQ, 4, number of requesters.
- NSLOT, 16, number of bullet slots; power of two, at least 2.
- SLOT_W, 4, slot index width, equal to log2(NSLOT).

Ports:
- clk  in  1  system clock.
- hard_reset_n  in  1  asynchronous active-low reset.
- game_en  in  1  grants allowed only while high.
- game_reset  in  1  sync pulse: flush all slots, reset arbitration.
- bomb_clear  in  1  sync pulse: flush all slots.
- req  in  NREQ  per-requester spawn request, level.
- release_valid  in  1  a slot is freed (bullet off-screen or hit).
- release_slot  in  SLOT_W  index of the freed slot.
- gnt  out  NREQ  one-hot grant, one-cycle pulse.
- gnt_valid  out  1  OR of gnt.
- gnt_slot  out  SLOT_W  allocated slot, valid with gnt_valid.
- flush_valid  out  1  bullet RAM must clear entry flush_slot this cycle.
- flush_slot  out  SLOT_W  slot being flushed.
- slot_busy  out  NSLOT  occupancy bitmap.
- busy_count  out  SLOT_W+1  number of busy slots.
- full  out  1  all slots busy.
- drop_count  out  8  saturating count of denied request cycles.

Behaviour:
- Reset (hard_reset_n low, async):
  - state OFF; rr_ptr=0.
  - gnt=0, gnt_valid=0, gnt_slot=0, flush_valid=0, flush_slot=0.
  - slot_busy=0, busy_count=0, full=0, drop_count=0.
  - Reset asserted mid-flush aborts the flush immediately.
- All outputs are registered.
- States:
  - OFF: no grants. Releases are honoured. Goes to RUN when game_en=1.
  - RUN: arbitrates as below. Goes to OFF when game_en=0; pending requests are not granted.
  - FLUSH: sweep counter runs 0..NSLOT-1, one slot per cycle. Each cycle asserts flush_valid with flush_slot=counter and clears slot_busy[counter]. After slot NSLOT-1 the next state is RUN if game_en=1, else OFF. Flush duration is exactly NSLOT cycles. No grants and releases ignored in FLUSH.
- game_reset in any state:
  - enters FLUSH with counter=0, rr_ptr=0, drop_count=0.
  - Has priority over bomb_clear, req and release in the same cycle.
- bomb_clear in OFF or RUN: enters FLUSH with counter=0; rr_ptr and drop_count unchanged.
- bomb_clear during FLUSH: ignored.
- game_reset during FLUSH: restarts the sweep at 0.
- Arbitration in RUN, request sampled in cycle t, grant registered at t+1 (latency 1):
  - Winner: the first set req bit scanning from rr_ptr upward, wrapping modulo NREQ.
  - gnt_slot: lowest index with slot_busy=0, evaluated on the registered bitmap before this cycle's release.
  - Same cycle as the grant: slot_busy[gnt_slot] is set and rr_ptr = winner+1 mod NREQ.
  - A requester holding req competes again next cycle; a single requester may win on consecutive cycles.
- Full (all slots busy, any req set, RUN): no grant, rr_ptr unchanged, drop_count += 1, saturating at 255.
- Release:
  - release_valid clears slot_busy[release_slot] (OFF/RUN only).
  - Release of an already-free slot is a no-op.
  - A slot released in cycle t is allocatable from t+1.
  - Grant and release in the same cycle: both apply; busy_count is unchanged.
- busy_count and full are registered and consistent with slot_busy in the same cycle.

Test Plan:
1. Reset, game_en=1, req=4'b0001 for one cycle -> one cycle later gnt=0001, gnt_slot=0, slot_busy=0x0001, busy_count=1.
2. req=4'b1111 held 4 cycles from rr_ptr=0 -> grants 0001,0010,0100,1000 on consecutive cycles with slots 0,1,2,3; rr_ptr back to 0.
3. Fill all 16 slots, then hold req=0001 for 3 cycles -> no gnt, full=1, drop_count=3. Then release_slot=5 -> next grant gets slot 5, full=0.
4. Release slot 2 while it is free -> slot_busy and busy_count unchanged. Grant and release on the same cycle with busy_count=8 -> busy_count stays 8.
5. 10 slots busy, pulse bomb_clear -> flush_valid for 16 cycles with flush_slot 0..15, req ignored. Afterwards slot_busy=0, state RUN, drop_count unchanged.
6. game_reset at sweep slot 7 -> sweep restarts at 0, drop_count=0. hard_reset_n low mid-flush -> flush_valid=0 at once and all outputs at reset values.
